// File: rtl/dds_comb_interp.sv
// DDS-paced comb (first difference) stage: undoes an integrate-and-hold path by
// consuming one buffered integrated sample per phase-accumulator carry-out.
module dds_comb_interp #(
  parameter int BITWIDTH = 32,
  parameter int PA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                n_RST,
  input  logic [PA_WIDTH-1:0] tuning_word,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] sig_out,
  output logic                out_strobe,
  output logic                underrun,
  input  logic                clr_underrun
);

  // Two's complement difference with natural wrap; no saturation by design.
  function automatic logic signed [BITWIDTH-1:0] comb_wrap(
    input logic signed [BITWIDTH-1:0] cur,
    input logic signed [BITWIDTH-1:0] prv
  );
    return cur - prv;
  endfunction

  logic [PA_WIDTH-1:0]        acc_p0;
  logic [PA_WIDTH:0]          acc_sum;
  logic                       tick_p0;
  logic signed [BITWIDTH-1:0] buf_p0;
  logic signed [BITWIDTH-1:0] prev_p0;
  logic                       full_p0;
  logic signed [BITWIDTH-1:0] sig_p1;
  logic                       vld_p1;
  logic                       underrun_q;
  logic                       accept;

  assign acc_sum    = {1'b0, acc_p0} + {1'b0, tuning_word};
  assign tick_p0    = acc_sum[PA_WIDTH];
  assign in_ready   = !full_p0;
  assign accept     = in_valid && !full_p0;
  assign sig_out    = sig_p1;
  assign out_strobe = vld_p1;
  assign underrun   = underrun_q;

  // Stage p0 -> p1: accumulator/buffer update and comb output register.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      acc_p0     <= '0;
      buf_p0     <= '0;
      prev_p0    <= '0;
      full_p0    <= 1'b0;
      sig_p1     <= '0;
      vld_p1     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      acc_p0 <= acc_sum[PA_WIDTH-1:0];
      vld_p1 <= tick_p0;
      if (tick_p0 && full_p0) begin
        sig_p1  <= comb_wrap(buf_p0, prev_p0);
        prev_p0 <= buf_p0;
        full_p0 <= 1'b0;
      end else begin
        // An underrun tick never takes a sample arriving on the same edge.
        if (tick_p0) sig_p1 <= '0;
        if (accept) begin
          buf_p0  <= $signed(in_data);
          full_p0 <= 1'b1;
        end
      end
      if (tick_p0 && !full_p0) underrun_q <= 1'b1;
      else if (clr_underrun)   underrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_comb_interp.sv
// Scoreboard bench for dds_comb_interp: a phase/queue reference model pushes
// expected strobe values; a monitor pops and compares on every out_strobe.
module tb_dds_comb_interp;
  localparam int BW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          n_RST = 1'b0;
  logic [PW-1:0] tuning_word = 8'd64;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          clr_underrun = 1'b0;
  logic          in_ready;
  logic [BW-1:0] sig_out;
  logic          out_strobe;
  logic          underrun;

  always #5 clk = ~clk;

  dds_comb_interp #(.BITWIDTH(BW), .PA_WIDTH(PW)) dut (
    .clk(clk), .n_RST(n_RST), .tuning_word(tuning_word), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sig_out(sig_out),
    .out_strobe(out_strobe), .underrun(underrun), .clr_underrun(clr_underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer phase with carry test, pending-sample queue.
  int            phase = 0;
  int            nxt;
  bit            tk;
  bit            acc_now;
  logic [BW-1:0] pend_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] m_prev = '0;
  logic [BW-1:0] m_sig = '0;
  bit            m_und = 1'b0;

  always @(negedge n_RST) begin
    phase = 0; m_prev = '0; m_sig = '0; m_und = 1'b0;
    pend_q.delete(); exp_q.delete();
  end

  always @(posedge clk) begin
    if (n_RST) begin
      nxt     = phase + int'(tuning_word);
      tk      = (nxt >= (1 << PW));
      phase   = nxt % (1 << PW);
      acc_now = in_valid && (pend_q.size() == 0);
      if (clr_underrun) m_und = 1'b0;
      if (tk) begin
        if (pend_q.size() != 0) begin
          m_sig  = pend_q[0] - m_prev;
          m_prev = pend_q.pop_front();
        end else begin
          m_sig = '0;
          m_und = 1'b1;
        end
        exp_q.push_back(m_sig);
      end
      if (acc_now) pend_q.push_back(in_data);
    end
  end

  // Monitor: outputs sampled 1 time unit after each rising edge.
  int            cyc = 0;
  logic [BW-1:0] mon_e;
  logic [BW-1:0] seen_q[$];
  int            seen_t[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!n_RST) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_sig_out", sig_out, 0);
      check("rst_out_strobe", out_strobe, 0);
      check("rst_underrun", underrun, 0);
    end else begin
      check("in_ready", in_ready, pend_q.size() == 0);
      check("underrun", underrun, m_und);
      check("out_strobe", out_strobe, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sig_out", sig_out, mon_e);
        if (out_strobe) begin
          seen_q.push_back(sig_out);
          seen_t.push_back(cyc);
        end
      end else begin
        check("sig_out_hold", sig_out, m_sig);
      end
    end
  end

  task automatic send(input logic [BW-1:0] x);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    for (int k = 0; k < 64 && !in_ready; k++) @(negedge clk);
    check("send_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_seen(input int n);
    for (int k = 0; k < 200 && seen_q.size() < n; k++) @(negedge clk);
    check("strobe_timeout", seen_q.size() >= n, 1);
  endtask

  task automatic clear_log();
    seen_q.delete();
    seen_t.delete();
  endtask

  logic r;
  logic [PW-1:0] tw_tab[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held from time zero.
    #12;
    check("init_in_ready", in_ready, 1);
    check("init_sig_out", sig_out, 0);
    check("init_strobe", out_strobe, 0);
    @(negedge clk);
    n_RST = 1'b1;

    // Comb sequence.
    clear_log();
    send(16'd10); send(16'd25); send(16'd25); send(16'd7);
    wait_seen(4);
    check("comb_0", seen_q[0], 16'd10);
    check("comb_1", seen_q[1], 16'd15);
    check("comb_2", seen_q[2], 16'd0);
    check("comb_3", seen_q[3], 16'hFFEE);
    check("comb_spacing", seen_t[3] - seen_t[0], 12);

    // Wrap arithmetic.
    clear_log();
    send(16'hFFF0); send(16'h0010);
    wait_seen(2);
    check("wrap", seen_q[1], 16'h0020);

    // Underrun, recovery, clear, and set-wins-over-clear.
    clear_log();
    send(16'd40);
    wait_seen(1);
    wait_seen(2);
    check("underrun_out", seen_q[1], 16'd0);
    check("underrun_set", underrun, 1);
    send(16'd50);
    wait_seen(3);
    check("after_underrun", seen_q[2], 16'd10);
    @(negedge clk); clr_underrun = 1'b1;
    @(negedge clk); clr_underrun = 1'b0;
    check("underrun_clr", underrun, 0);
    clr_underrun = 1'b1;
    wait_seen(4);
    check("underrun_set_wins", underrun, 1);
    clr_underrun = 1'b0;

    // Backpressure with continuous valid and incrementing data.
    clear_log();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd100;
    for (int k = 0; k < 40; k++) begin
      r = in_ready;
      @(negedge clk);
      if (r) in_data = in_data + 16'd1;
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("bp_count", seen_q.size() >= 8, 1);
    check("bp_first", seen_q[0], 16'd50);
    for (int k = 1; k < seen_q.size(); k++) check("bp_step", seen_q[k], 16'd1);

    // Reset with a buffered sample, then the first sample is emitted as is.
    send(16'd500);
    check("full_before_rst", in_ready, 0);
    #2;
    n_RST = 1'b0;
    #1;
    check("async_rst_ready", in_ready, 1);
    check("async_rst_sig", sig_out, 0);
    check("async_rst_strobe", out_strobe, 0);
    check("async_rst_und", underrun, 0);
    @(negedge clk);
    n_RST = 1'b1;
    clear_log();
    send(16'h1234);
    wait_seen(1);
    check("post_rst_first", seen_q[0], 16'h1234);

    // Randomized traffic across several tuning words, including full scale.
    tw_tab[0] = 8'd64;  tw_tab[1] = 8'd32; tw_tab[2] = 8'd128;
    tw_tab[3] = 8'd255; tw_tab[4] = 8'($urandom_range(1, 255)); tw_tab[5] = 8'd16;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      tuning_word = tw_tab[t];
      repeat (150) begin
        @(negedge clk);
        in_valid     = ($urandom % 3) != 0;
        in_data      = 16'($urandom);
        clr_underrun = ($urandom % 8) == 0;
      end
    end

    // Zero tuning word: never a strobe, even across a reset.
    @(negedge clk);
    tuning_word = '0;
    clear_log();
    repeat (60) begin
      @(negedge clk);
      in_valid = ($urandom % 2) != 0;
      in_data  = 16'($urandom);
    end
    #2; n_RST = 1'b0;
    @(negedge clk); n_RST = 1'b1;
    repeat (40) begin
      @(negedge clk);
      in_valid = ($urandom % 2) != 0;
      in_data  = 16'($urandom);
    end
    in_valid = 1'b0;
    check("tw0_no_strobe", seen_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
